// File: rtl/beam_pkg.sv
// rtl/beam_pkg.sv - shared sizes, FSM encoding and read-tag type for the beam summing stage
package beam_pkg;

    localparam int BEAM_NUM_CH    = 8;
    localparam int BEAM_SAMPLES   = 768;
    localparam int BEAM_DATA_W    = 32;
    localparam int BEAM_SUM_W     = 40;
    localparam int BEAM_RD_ADDR_W = 13;
    localparam int BEAM_WR_ADDR_W = 10;
    localparam int BEAM_RD_LAT    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Travels alongside each output-RAM read so the returning word knows
    // whether it opens or closes a sample and which sample it belongs to.
    typedef struct packed {
        logic                      valid;
        logic                      first;
        logic                      last;
        logic [BEAM_WR_ADDR_W-1:0] t;
    } tag_t;

endpackage

// File: rtl/read_tag_pipe.sv
// rtl/read_tag_pipe.sv - fixed-depth shift pipe that delays read tags to match RAM latency
module read_tag_pipe
    import beam_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_clear,
    input  tag_t i_tag,
    output tag_t o_tag
);

    tag_t r_stage [DEPTH];

    // Advance one stage per cycle; clear discards every in-flight tag
    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/beam_sum_sequencer.sv
// rtl/beam_sum_sequencer.sv - streams output-RAM reads, sums channels per sample, writes sum RAM
module beam_sum_sequencer
    import beam_pkg::*;
#(
    parameter int NUM_CH    = BEAM_NUM_CH,
    parameter int SAMPLES   = BEAM_SAMPLES,
    parameter int DATA_W    = BEAM_DATA_W,
    parameter int SUM_W     = BEAM_SUM_W,
    parameter int RD_ADDR_W = BEAM_RD_ADDR_W,
    parameter int WR_ADDR_W = BEAM_WR_ADDR_W,
    parameter int RD_LAT    = BEAM_RD_LAT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 out_rd_en,
    output logic [RD_ADDR_W-1:0] out_rd_addr,
    input  logic [DATA_W-1:0]    out_rd_data,
    output logic                 sum_wr_en,
    output logic [WR_ADDR_W-1:0] sum_wr_addr,
    output logic [SUM_W-1:0]     sum_wr_data
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DR_W = $clog2(RD_LAT + 2);

    localparam logic [CH_W-1:0]      LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic [WR_ADDR_W-1:0] LAST_T    = WR_ADDR_W'(SAMPLES - 1);
    localparam logic [RD_ADDR_W-1:0] CH_STRIDE = RD_ADDR_W'(SAMPLES);
    localparam logic [DR_W-1:0]      DRAIN_END = DR_W'(RD_LAT);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WR_ADDR_W-1:0] r_t;
    logic [CH_W-1:0]      r_s;
    logic [RD_ADDR_W-1:0] r_ch_base;
    logic [DR_W-1:0]      r_drain_cnt;
    logic [SUM_W-1:0]     r_acc;

    logic                 w_last_ch;
    logic                 w_last_read;
    tag_t                 w_tag_in;
    tag_t                 w_tag_out;
    logic [SUM_W-1:0]     w_word;
    logic [SUM_W-1:0]     w_sum;

    assign w_last_ch   = (r_s == LAST_CH);
    assign w_last_read = w_last_ch && (r_t == LAST_T);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state plus run-status and read-port outputs, all decoded from the current state
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        out_rd_en   = 1'b0;
        out_rd_addr = '0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                busy        = 1'b1;
                out_rd_en   = 1'b1;
                out_rd_addr = r_ch_base + RD_ADDR_W'(r_t);
                if (w_last_read) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (r_drain_cnt == DRAIN_END) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Walk channels fastest within each sample; the channel base steps by SAMPLES
    always_ff @(posedge clk) begin
        if (reset) begin
            r_t         <= '0;
            r_s         <= '0;
            r_ch_base   <= '0;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_t       <= '0;
                        r_s       <= '0;
                        r_ch_base <= '0;
                    end
                end
                ST_ISSUE: begin
                    r_drain_cnt <= '0;
                    if (w_last_ch) begin
                        r_s       <= '0;
                        r_ch_base <= '0;
                        r_t       <= r_t + WR_ADDR_W'(1);
                    end else begin
                        r_s       <= r_s + CH_W'(1);
                        r_ch_base <= r_ch_base + CH_STRIDE;
                    end
                end
                ST_DRAIN: r_drain_cnt <= r_drain_cnt + DR_W'(1);
                default: ;
            endcase
        end
    end

    // Tag for the read issued this cycle; an empty tag when no read goes out
    always_comb begin
        w_tag_in = '0;
        if (r_state == ST_ISSUE) begin
            w_tag_in.valid = 1'b1;
            w_tag_in.first = (r_s == '0);
            w_tag_in.last  = w_last_ch;
            w_tag_in.t     = BEAM_WR_ADDR_W'(r_t);
        end
    end

    read_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .i_clk   (clk),
        .i_clear (reset),
        .i_tag   (w_tag_in),
        .o_tag   (w_tag_out)
    );

    assign w_word = SUM_W'(out_rd_data);
    assign w_sum  = w_tag_out.first ? w_word : (r_acc + w_word);

    // Fold each returning word into the running sum; the sample's last word emits the write
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc       <= '0;
            sum_wr_en   <= 1'b0;
            sum_wr_addr <= '0;
            sum_wr_data <= '0;
        end else begin
            sum_wr_en <= 1'b0;
            if (w_tag_out.valid) begin
                r_acc <= w_sum;
                if (w_tag_out.last) begin
                    sum_wr_en   <= 1'b1;
                    sum_wr_addr <= WR_ADDR_W'(w_tag_out.t);
                    sum_wr_data <= w_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_beam_sum_sequencer.sv
// tb/tb_beam_sum_sequencer.sv - randomized self-checking bench for beam_sum_sequencer at RD_LAT 2, 1 and 4
module tb_beam_sum_sequencer;

    localparam int NCH = 8;
    localparam int NS  = 768;
    localparam int NW  = NCH * NS;

    typedef struct {
        int     inst;
        int     addr;
        longint data;
        int     cyc;
    } wr_rec_t;

    logic        clk;
    logic        reset;
    logic [2:0]  start;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [2:0]  rd_en;
    logic [2:0]  wr_en;
    logic [12:0] rd_addr [3];
    logic [31:0] rd_data [3];
    logic [9:0]  wr_addr [3];
    logic [39:0] wr_data [3];

    logic [31:0] mem [8192];
    longint      exp_sum [NS];

    int      cyc;
    int      c0;
    bit      run_go;
    bit      b2b_mode;
    int      quiet_after;
    int      start_at[$];
    int      reset_at[$];

    wr_rec_t wr_q[$];
    int      done_cnt   [3];
    int      done_cyc   [3];
    int      busy_cnt   [3];
    int      busy_first [3];
    int      busy_last  [3];
    int      noisy      [3];

    int      n_tests;
    int      n_fail;

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_lane
        localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        logic [12:0] dl [4];

        always @(posedge clk) begin
            dl[0] <= rd_addr[g];
            for (int i = 1; i < 4; i++) dl[i] <= dl[i-1];
        end

        assign rd_data[g] = mem[dl[L-1]];

        beam_sum_sequencer #(
            .RD_LAT (L)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .start       (start[g]),
            .busy        (busy[g]),
            .done        (done[g]),
            .out_rd_en   (rd_en[g]),
            .out_rd_addr (rd_addr[g]),
            .out_rd_data (rd_data[g]),
            .sum_wr_en   (wr_en[g]),
            .sum_wr_addr (wr_addr[g]),
            .sum_wr_data (wr_data[g])
        );
    end

    initial begin
        wr_rec_t rec;
        forever begin
            @(negedge clk);
            if (run_go) begin
                wr_q.delete();
                c0 = cyc;
                for (int k = 0; k < 3; k++) begin
                    done_cnt[k]   = 0;
                    done_cyc[k]   = -1;
                    busy_cnt[k]   = 0;
                    busy_first[k] = -1;
                    busy_last[k]  = -1;
                    noisy[k]      = 0;
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (wr_en[k]) begin
                    rec.inst = k;
                    rec.addr = int'(wr_addr[k]);
                    rec.data = longint'(wr_data[k]);
                    rec.cyc  = cyc - c0;
                    wr_q.push_back(rec);
                end
                if (done[k]) begin
                    done_cnt[k]++;
                    done_cyc[k] = cyc - c0;
                end
                if (busy[k]) begin
                    busy_cnt[k]++;
                    if (busy_first[k] < 0) busy_first[k] = cyc - c0;
                    busy_last[k] = cyc - c0;
                end
                if (((cyc - c0) > quiet_after) &&
                    (busy[k] || done[k] || rd_en[k] || wr_en[k] ||
                     (rd_addr[k] != '0) || (wr_addr[k] != '0) || (wr_data[k] != '0)))
                    noisy[k]++;
            end
        end
    end

    function automatic bit hit(input int q[$], input int v);
        foreach (q[i]) if (q[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: each sample's sum is the plain sum of its NCH channel words
    function automatic void fill_expected();
        for (int t = 0; t < NS; t++) begin
            exp_sum[t] = 0;
            for (int s = 0; s < NCH; s++) exp_sum[t] += longint'(mem[t + NS * s]);
        end
    endfunction

    // Index of the first write of lane k that departs from the reference (-1 if none)
    function automatic int first_bad(input int k, input int gap, output int nrec, output string info);
        int j;
        int t;
        int ecyc;
        first_bad = -1;
        info = "";
        j = 0;
        foreach (wr_q[i]) begin
            if (wr_q[i].inst == k) begin
                t    = j % NS;
                ecyc = (j / NS) * gap + NCH * t + 9 + lat_of(k);
                if (first_bad < 0 && (wr_q[i].addr != t || wr_q[i].data != exp_sum[t] || wr_q[i].cyc != ecyc)) begin
                    first_bad = j;
                    info = $sformatf("got addr %0d data %0h cyc %0d, want addr %0d data %0h cyc %0d",
                                     wr_q[i].addr, wr_q[i].data, wr_q[i].cyc, t, exp_sum[t], ecyc);
                end
                j++;
            end
        end
        nrec = j;
    endfunction

    task automatic run_cycles(input int n);
        int dc;
        @(posedge clk); #1;
        run_go = 1'b1;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 3; k++) begin
                dc = NW + lat_of(k) + 2;
                start[k] = b2b_mode ? (i == 0 || i == 500 || i == dc || i == dc + 1) : hit(start_at, i);
            end
            reset = hit(reset_at, i);
            @(posedge clk); #1;
            run_go = 1'b0;
        end
        start = '0;
        reset = 1'b0;
    endtask

    task automatic load_ramp();
        for (int a = 0; a < NW; a++) mem[a] = 32'(a);
        fill_expected();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({busy, done, rd_en, wr_en} !== 12'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0", {busy, done, rd_en, wr_en});
        end
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if ({rd_addr[k], wr_addr[k], wr_data[k]} !== 63'b0) begin
                n_fail++;
                $display("FAIL reset_buses lane%0d: got rd_addr %0h wr_addr %0h wr_data %0h want 0",
                         k, rd_addr[k], wr_addr[k], wr_data[k]);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int    nrec;
        int    bad;
        int    want;
        string info;
        load_ramp();
        start_at.delete(); start_at.push_back(0);
        reset_at.delete(); reset_at.push_back(3000);
        quiet_after = 3000;
        run_cycles(3300);
        reset_at.delete();
        quiet_after = 1 << 30;
        for (int k = 0; k < 3; k++) begin
            bad  = first_bad(k, 0, nrec, info);
            want = (3000 - 9 - lat_of(k)) / NCH + 1;
            n_tests++;
            if (nrec !== want) begin
                n_fail++;
                $display("FAIL midreset_count lane%0d: got %0d writes want %0d", k, nrec, want);
            end
            n_tests++;
            if (bad !== -1) begin
                n_fail++;
                $display("FAIL midreset_prefix lane%0d: write %0d %s", k, bad, info);
            end
            n_tests++;
            if (done_cnt[k] !== 0) begin
                n_fail++;
                $display("FAIL midreset_done lane%0d: got %0d done pulses want 0", k, done_cnt[k]);
            end
            n_tests++;
            if (noisy[k] !== 0) begin
                n_fail++;
                $display("FAIL midreset_quiet lane%0d: got %0d active cycles after reset want 0", k, noisy[k]);
            end
        end
    endtask

    task automatic test_ramp();
        int    nrec;
        int    bad;
        int    i0;
        int    i1;
        int    lat;
        string info;
        load_ramp();
        start_at.delete(); start_at.push_back(0);
        run_cycles(NW + 20);
        for (int k = 0; k < 3; k++) begin
            lat = lat_of(k);
            bad = first_bad(k, 0, nrec, info);
            n_tests++;
            if (nrec !== NS) begin
                n_fail++;
                $display("FAIL ramp_count lane%0d: got %0d writes want %0d", k, nrec, NS);
            end
            n_tests++;
            if (bad !== -1) begin
                n_fail++;
                $display("FAIL ramp_writes lane%0d: write %0d %s", k, bad, info);
            end
            n_tests++;
            if (done_cnt[k] !== 1 || done_cyc[k] !== NW + lat + 2) begin
                n_fail++;
                $display("FAIL ramp_done lane%0d: got %0d pulses last cyc %0d want 1 at %0d",
                         k, done_cnt[k], done_cyc[k], NW + lat + 2);
            end
            n_tests++;
            if (busy_first[k] !== 1 || busy_last[k] !== NW + lat + 1 || busy_cnt[k] !== NW + lat + 1) begin
                n_fail++;
                $display("FAIL ramp_busy lane%0d: got first %0d last %0d count %0d want 1 %0d %0d",
                         k, busy_first[k], busy_last[k], busy_cnt[k], NW + lat + 1, NW + lat + 1);
            end
        end
        i0 = -1;
        i1 = -1;
        foreach (wr_q[i]) begin
            if (wr_q[i].inst == 0) begin
                if (i0 < 0) i0 = i;
                i1 = i;
            end
        end
        n_tests++;
        if (i0 < 0 || wr_q[i0].data !== 64'd21504 || wr_q[i0].cyc !== 11) begin
            n_fail++;
            $display("FAIL ramp_first: got idx %0d data %0d cyc %0d want data 21504 cyc 11",
                     i0, (i0 < 0) ? 0 : wr_q[i0].data, (i0 < 0) ? 0 : wr_q[i0].cyc);
        end
        n_tests++;
        if (i1 < 0 || wr_q[i1].data !== 64'd27640 || wr_q[i1].cyc !== 6147 || wr_q[i1].addr !== 767) begin
            n_fail++;
            $display("FAIL ramp_last: got idx %0d addr %0d data %0d cyc %0d want addr 767 data 27640 cyc 6147",
                     i1, (i1 < 0) ? 0 : wr_q[i1].addr, (i1 < 0) ? 0 : wr_q[i1].data, (i1 < 0) ? 0 : wr_q[i1].cyc);
        end
    endtask

    task automatic test_all_ones();
        int    nrec;
        int    bad;
        int    nconst;
        string info;
        for (int a = 0; a < NW; a++) mem[a] = 32'hFFFF_FFFF;
        fill_expected();
        start_at.delete(); start_at.push_back(0);
        run_cycles(NW + 20);
        nconst = 0;
        foreach (wr_q[i]) if (wr_q[i].data != 64'h7_FFFF_FFF8) nconst++;
        n_tests++;
        if (wr_q.size() !== 3 * NS || nconst !== 0) begin
            n_fail++;
            $display("FAIL ones_value: got %0d writes with %0d not equal 7fffffff8 want %0d writes all equal",
                     wr_q.size(), nconst, 3 * NS);
        end
        for (int k = 0; k < 3; k++) begin
            bad = first_bad(k, 0, nrec, info);
            n_tests++;
            if (nrec !== NS || bad !== -1) begin
                n_fail++;
                $display("FAIL ones_writes lane%0d: count %0d (want %0d) first bad %0d %s", k, nrec, NS, bad, info);
            end
        end
    endtask

    task automatic test_random();
        int    nrec;
        int    bad;
        string info;
        for (int a = 0; a < NW; a++) mem[a] = $urandom;
        fill_expected();
        start_at.delete(); start_at.push_back(0);
        run_cycles(NW + 20);
        for (int k = 0; k < 3; k++) begin
            bad = first_bad(k, 0, nrec, info);
            n_tests++;
            if (nrec !== NS || bad !== -1) begin
                n_fail++;
                $display("FAIL random_writes lane%0d: count %0d (want %0d) first bad %0d %s", k, nrec, NS, bad, info);
            end
            n_tests++;
            if (done_cnt[k] !== 1) begin
                n_fail++;
                $display("FAIL random_done lane%0d: got %0d pulses want 1", k, done_cnt[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int    nrec;
        int    bad;
        int    lat;
        string info;
        load_ramp();
        b2b_mode = 1'b1;
        run_cycles(2 * NW + 30);
        b2b_mode = 1'b0;
        for (int k = 0; k < 3; k++) begin
            lat = lat_of(k);
            bad = first_bad(k, NW + lat + 3, nrec, info);
            n_tests++;
            if (nrec !== 2 * NS || bad !== -1) begin
                n_fail++;
                $display("FAIL b2b_writes lane%0d: count %0d (want %0d) first bad %0d %s", k, nrec, 2 * NS, bad, info);
            end
            n_tests++;
            if (done_cnt[k] !== 2 || done_cyc[k] !== 2 * NW + 2 * lat + 5) begin
                n_fail++;
                $display("FAIL b2b_done lane%0d: got %0d pulses last cyc %0d want 2 at %0d",
                         k, done_cnt[k], done_cyc[k], 2 * NW + 2 * lat + 5);
            end
            n_tests++;
            if (busy_cnt[k] !== 2 * (NW + lat + 1)) begin
                n_fail++;
                $display("FAIL b2b_busy lane%0d: got %0d busy cycles want %0d", k, busy_cnt[k], 2 * (NW + lat + 1));
            end
        end
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        run_go      = 1'b0;
        b2b_mode    = 1'b0;
        quiet_after = 1 << 30;
        start       = '0;
        reset       = 1'b1;
        test_reset();
        test_reset_mid_run();
        test_ramp();
        test_all_ones();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
